regfile_alu_pipe: RTL

//  Parametrised 2-stage register-file + ALU execute block with valid/ready flow control on input and output.

---
 rtl/regfile_alu_pkg.sv | 19 +
 rtl/regfile_alu_pipe_alu_core.sv | 39 +++
 rtl/regfile_alu_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_alu_pkg.sv
// Shared ALU op encoding for the register-file execute block.
package regfile_alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'd9;
    localparam logic [OP_W-1:0] OP_ADD3  = 4'd10;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd11;

endpackage

// File: rtl/regfile_alu_pipe_alu_core.sv
// Combinational ALU: result from op, operand a, operand b and the raw immediate.
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int REG_WIDTH = 64
) (
    input  logic [OP_W-1:0]      op,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  logic [REG_WIDTH-1:0] imm,
    output logic [REG_WIDTH-1:0] result
);

    localparam int S = $clog2(REG_WIDTH);

    logic [S-1:0] shamt;
    assign shamt = b[S-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_SRA:   result = $signed(a) >>> shamt;
            OP_SLT:   result = {{(REG_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  result = {{(REG_WIDTH-1){1'b0}}, (a < b)};
            // b carries rs2 here; the top never substitutes the immediate for ADD3
            OP_ADD3:  result = a + b + imm;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Two-stage execute block: issue register (S1) reads the regfile, output register (S2)
// holds the result; writeback happens on the same edge the result enters S2.
module regfile_alu_pipe
    import regfile_alu_pkg::*;
#(
    parameter int REG_WIDTH  = 64,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       in_op,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_immflag,
    input  logic [REG_WIDTH-1:0]  in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_WIDTH-1:0]  out_result,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_zero
);

    logic [REG_WIDTH-1:0]  regs [REG_COUNT];

    logic                  s1_valid;
    logic [OP_W-1:0]       s1_op;
    logic [ADDR_WIDTH-1:0] s1_rs1;
    logic [ADDR_WIDTH-1:0] s1_rs2;
    logic [ADDR_WIDTH-1:0] s1_rd;
    logic                  s1_immflag;
    logic [REG_WIDTH-1:0]  s1_imm;

    logic [REG_WIDTH-1:0]  rs1_val;
    logic [REG_WIDTH-1:0]  rs2_val;
    logic [REG_WIDTH-1:0]  opb;
    logic [REG_WIDTH-1:0]  alu_result;
    logic                  advance;

    assign advance  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || advance;

    // Index 0 and indices past the implemented registers read as zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (s1_rs1 != '0 && int'(s1_rs1) < REG_COUNT) rs1_val = regs[s1_rs1];
        if (s1_rs2 != '0 && int'(s1_rs2) < REG_COUNT) rs2_val = regs[s1_rs2];
    end

    assign opb = (s1_immflag && s1_op != OP_ADD3) ? s1_imm : rs2_val;

    alu_core #(.REG_WIDTH(REG_WIDTH)) u_alu (
        .op     (s1_op),
        .a      (rs1_val),
        .b      (opb),
        .imm    (s1_imm),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_rd      <= '0;
            s1_immflag <= 1'b0;
            s1_imm     <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid   <= 1'b1;
            s1_op      <= in_op;
            s1_rs1     <= in_rs1;
            s1_rs2     <= in_rs2;
            s1_rd      <= in_rd;
            s1_immflag <= in_immflag;
            s1_imm     <= in_imm;
        end else if (advance) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_zero   <= 1'b1;
        end else if (advance) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_rd     <= s1_rd;
            out_zero   <= (alu_result == '0);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Writing at advance lets the next op, now in S1, read the fresh value without a bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (advance && s1_rd != '0 && int'(s1_rd) < REG_COUNT) begin
            regs[s1_rd] <= alu_result;
        end
    end

endmodule
